// File: rtl/seq_long_divider.sv
// Sequential restoring long divider, one quotient bit per clock.
// Start/done handshake, divide-by-zero flag, results held between ops.
module seq_long_divider #(
  parameter int DW = 8,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] D,
  input  logic [MW-1:0] M,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] Q,
  output logic [MW-1:0] R,
  output logic          div0
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q;
  logic [DW-1:0] d_sh_q;
  logic [MW-1:0] m_q;
  logic [MW:0]   rem_q;
  logic [DW-1:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic          zero_q;
  logic [DW-1:0] q_q;
  logic [MW-1:0] r_q;
  logic          div0_q;
  logic          done_q;

  logic [MW:0]   t;
  logic          ge;
  logic [MW:0]   rem_d;
  logic [DW-1:0] quo_d;

  // One restoring step: trial subtract of the divisor from the shifted remainder.
  always_comb begin
    t     = {rem_q[MW-1:0], d_sh_q[DW-1]};
    ge    = (t >= {1'b0, m_q});
    rem_d = ge ? (t - {1'b0, m_q}) : t;
    quo_d = {quo_q[DW-2:0], ge};
  end

  // Control FSM and datapath; a zero divisor takes a single CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_sh_q  <= '0;
      m_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            d_sh_q  <= D;
            m_q     <= M;
            rem_q   <= '0;
            quo_q   <= '0;
            state_q <= CALC;
            if (M != '0) begin
              cnt_q  <= CW'(DW);
              zero_q <= 1'b0;
            end else begin
              cnt_q  <= CW'(1);
              zero_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (zero_q) begin
            q_q     <= '1;
            r_q     <= d_sh_q[MW-1:0];
            div0_q  <= 1'b1;
            done_q  <= 1'b1;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            d_sh_q <= {d_sh_q[DW-2:0], 1'b0};
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              q_q     <= quo_d;
              r_q     <= rem_d[MW-1:0];
              div0_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = (state_q != CALC);
  assign busy  = (state_q == CALC);
  assign done  = done_q;
  assign Q     = q_q;
  assign R     = r_q;
  assign div0  = div0_q;

endmodule
